commit_mem_access_ctrl: RTL

Commit-stage memory access sequencer. Takes one load or store from the commit stage and performs a TLB translation, then a cache access. Returns load data and the destination register, or a fault cause, to writeback. Parametrised successor of the fixed-width commit request/response bundle, adding handshaking, miss/stall handling, a timeout and fault reporting.

---
 rtl/commit_mem_access_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/commit_mem_access_ctrl.sv
// Commit-stage memory access sequencer: one load/store at a time through TLB translation then cache access.
// Define COMMIT_MEM_PERF_CNT_EN to add saturating TLB-miss, cache-stall and fault event counters.
module commit_mem_access_ctrl #(
    parameter int VADDR_W       = 32,
    parameter int PADDR_W       = 20,
    parameter int DATA_W        = 32,
    parameter int REG_IDX_W     = 5,
    parameter int PAGE_OFFSET_W = 12,
    parameter int TIMEOUT       = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic                 req_mode,
    input  logic [VADDR_W-1:0]   req_vaddr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [REG_IDX_W-1:0] req_rd,
    output logic                 tlb_enable,
    output logic [VADDR_W-1:0]   tlb_addr,
    input  logic                 tlb_hit,
    input  logic [PADDR_W-1:0]   tlb_paddr,
    output logic                 cache_read,
    output logic                 cache_write,
    output logic                 cache_mode,
    output logic [PADDR_W-1:0]   cache_addr,
    output logic [DATA_W-1:0]    cache_data_in,
    input  logic                 cache_hit,
    input  logic [DATA_W-1:0]    cache_data_out,
    output logic                 resp_valid,
    output logic [DATA_W-1:0]    resp_rdata,
    output logic [REG_IDX_W-1:0] resp_rd,
    output logic [1:0]           resp_fault
`ifdef COMMIT_MEM_PERF_CNT_EN
    ,
    output logic [31:0]          perf_tlb_miss,
    output logic [31:0]          perf_cache_stall,
    output logic [31:0]          perf_fault
`endif
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [VADDR_W-1:0] ALIGN_MASK = VADDR_W'((DATA_W / 8) - 1);
    localparam logic [PADDR_W-1:0] PG_MASK    = PADDR_W'((64'd1 << PAGE_OFFSET_W) - 64'd1);

    typedef enum logic [1:0] {S_IDLE, S_TLB, S_CACHE, S_RESP} state_t;

    state_t               state_reg, state_next;
    logic                 write_reg, write_next;
    logic                 mode_reg, mode_next;
    logic [VADDR_W-1:0]   vaddr_reg, vaddr_next;
    logic [DATA_W-1:0]    wdata_reg, wdata_next;
    logic [REG_IDX_W-1:0] rd_reg, rd_next;
    logic [PADDR_W-1:0]   paddr_reg, paddr_next;
    logic [DATA_W-1:0]    rdata_reg, rdata_next;
    logic [1:0]           fault_reg, fault_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;

    always_comb begin
        state_next = state_reg;
        write_next = write_reg;
        mode_next  = mode_reg;
        vaddr_next = vaddr_reg;
        wdata_next = wdata_reg;
        rd_next    = rd_reg;
        paddr_next = paddr_reg;
        rdata_next = rdata_reg;
        fault_next = fault_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    write_next = req_write;
                    mode_next  = req_mode;
                    vaddr_next = req_vaddr;
                    // Store data is byte-formatted once here so the cache sees a stable value.
                    wdata_next = req_mode ? DATA_W'(req_wdata[7:0]) : req_wdata;
                    rd_next    = req_rd;
                    rdata_next = '0;
                    fault_next = 2'b00;
                    if (!req_mode && (req_vaddr & ALIGN_MASK) != '0) begin
                        fault_next = 2'b10;
                        state_next = S_RESP;
                    end else begin
                        state_next = S_TLB;
                    end
                end
            end
            S_TLB: begin
                if (tlb_hit) begin
                    paddr_next = (tlb_paddr & ~PG_MASK) | (PADDR_W'(vaddr_reg) & PG_MASK);
                    cnt_next   = '0;
                    state_next = S_CACHE;
                end else begin
                    fault_next = 2'b01;
                    state_next = S_RESP;
                end
            end
            S_CACHE: begin
                if (cache_hit) begin
                    if (!write_reg) begin
                        rdata_next = mode_reg ? DATA_W'(cache_data_out[7:0]) : cache_data_out;
                    end
                    state_next = S_RESP;
                end else if (TIMEOUT != 0 && cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    fault_next = 2'b11;
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            write_reg <= 1'b0;
            mode_reg  <= 1'b0;
            vaddr_reg <= '0;
            wdata_reg <= '0;
            rd_reg    <= '0;
            paddr_reg <= '0;
            rdata_reg <= '0;
            fault_reg <= 2'b00;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            write_reg <= write_next;
            mode_reg  <= mode_next;
            vaddr_reg <= vaddr_next;
            wdata_reg <= wdata_next;
            rd_reg    <= rd_next;
            paddr_reg <= paddr_next;
            rdata_reg <= rdata_next;
            fault_reg <= fault_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Every output is a decode of registered state; nothing flows through from req_*.
    assign req_ready     = (state_reg == S_IDLE);
    assign tlb_enable    = (state_reg == S_TLB);
    assign tlb_addr      = vaddr_reg;
    assign cache_read    = (state_reg == S_CACHE) && !write_reg;
    assign cache_write   = (state_reg == S_CACHE) && write_reg;
    assign cache_mode    = mode_reg;
    assign cache_addr    = paddr_reg;
    assign cache_data_in = wdata_reg;
    assign resp_valid    = (state_reg == S_RESP);
    assign resp_rdata    = rdata_reg;
    assign resp_rd       = rd_reg;
    assign resp_fault    = fault_reg;

`ifdef COMMIT_MEM_PERF_CNT_EN
    logic [31:0] perf_tlb_miss_reg, perf_cache_stall_reg, perf_fault_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_tlb_miss_reg    <= '0;
            perf_cache_stall_reg <= '0;
            perf_fault_reg       <= '0;
        end else begin
            if (state_reg == S_TLB && !tlb_hit && perf_tlb_miss_reg != '1) begin
                perf_tlb_miss_reg <= perf_tlb_miss_reg + 32'd1;
            end
            if (state_reg == S_CACHE && !cache_hit && perf_cache_stall_reg != '1) begin
                perf_cache_stall_reg <= perf_cache_stall_reg + 32'd1;
            end
            if (state_reg == S_RESP && fault_reg != 2'b00 && perf_fault_reg != '1) begin
                perf_fault_reg <= perf_fault_reg + 32'd1;
            end
        end
    end

    assign perf_tlb_miss    = perf_tlb_miss_reg;
    assign perf_cache_stall = perf_cache_stall_reg;
    assign perf_fault       = perf_fault_reg;
`endif

endmodule
